// File: rtl/inst_sram_slave.sv
// Instruction-fetch SRAM slave: single outstanding request, fixed response latency,
// side-band preload port usable in any state.
module inst_sram_slave #(
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
    parameter int unsigned DEPTH     = 1024,
    parameter int unsigned LATENCY   = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [31:0] req_addr_i,
    output logic        resp_valid_o,
    input  logic        resp_ready_i,
    output logic [31:0] resp_data_o,
    output logic        resp_err_o,
    input  logic        load_en_i,
    input  logic [31:0] load_addr_i,
    input  logic [31:0] load_data_i
);
    // state | meaning
    // IDLE  | ready for a fetch request
    // WAIT  | request accepted, latency counter running
    // RESP  | response presented until the requester takes it
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    localparam int unsigned IW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [32:0] SPAN     = 33'(DEPTH) * 33'd4;
    localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

    state_t      state, state_next;
    logic [3:0]  cnt, cnt_next;
    logic [31:0] addr_q;
    logic [31:0] fetch_addr;
    logic        accept;
    logic        enter_resp;
    logic [31:0] mem [DEPTH];

    // 33-bit range compare so a 4*DEPTH span reaching 2^32 cannot wrap
    function automatic logic addr_ok(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE_ADDR;
        return (a[1:0] == 2'b00) && (a >= BASE_ADDR) && ({1'b0, off} < SPAN);
    endfunction

    function automatic logic [IW-1:0] word_idx(input logic [31:0] a);
        return IW'((a - BASE_ADDR) >> 2);
    endfunction

    assign req_ready_o  = (state == IDLE);
    assign resp_valid_o = (state == RESP);
    assign accept       = req_valid_i && req_ready_o;
    assign enter_resp   = (state != RESP) && (state_next == RESP);

    // with LATENCY = 1 the response is captured on the accept edge, before addr_q is loaded
    assign fetch_addr   = (state == IDLE) ? req_addr_i : addr_q;

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (LATENCY == 1) begin
                        state_next = RESP;
                    end else begin
                        cnt_next   = CNT_INIT;
                        state_next = WAIT;
                    end
                end
            end
            WAIT: begin
                cnt_next = cnt - 4'd1;
                if (cnt == 4'd1) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                if (resp_ready_i) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_ff @(posedge clk_i) begin
        if (accept) begin
            addr_q <= req_addr_i;
        end
    end

    // mem read here sees the pre-load value when a load hits the same word this edge
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            resp_data_o <= 32'd0;
            resp_err_o  <= 1'b0;
        end else if (enter_resp) begin
            if (addr_ok(fetch_addr)) begin
                resp_data_o <= mem[word_idx(fetch_addr)];
                resp_err_o  <= 1'b0;
            end else begin
                resp_data_o <= 32'd0;
                resp_err_o  <= 1'b1;
            end
        end else if (resp_valid_o && resp_ready_i) begin
            resp_data_o <= 32'd0;
            resp_err_o  <= 1'b0;
        end
    end

    // preload ignores reset and FSM state; faulting addresses are dropped
    always_ff @(posedge clk_i) begin
        if (load_en_i && addr_ok(load_addr_i)) begin
            mem[word_idx(load_addr_i)] <= load_data_i;
        end
    end

endmodule

// File: doc/inst_sram_slave.md
INST_SRAM_SLAVE -- requirements
Module: inst_sram_slave

Interface
REQ-001 The block SHALL have parameter BASE_ADDR, default 32'h80000000, byte address of word 0.
REQ-002 The block SHALL have parameter DEPTH, default 1024, number of 32-bit words stored.
REQ-003 The block SHALL have parameter LATENCY, default 2, legal range 1..15, cycles from request accept to response valid.
REQ-004 The block SHALL have one clock; reset is synchronous and active-high.
REQ-005 clk_i  input  1  clock; all state changes on its rising edge.
REQ-006 rst_i  input  1  synchronous active-high reset.
REQ-007 req_valid_i  input  1  fetch request valid.
REQ-008 req_ready_o  output  1  block can accept a request.
REQ-009 req_addr_i  input  32  fetch byte address.
REQ-010 resp_valid_o  output  1  response valid.
REQ-011 resp_ready_i  input  1  requester accepts response.
REQ-012 resp_data_o  output  32  fetched instruction word.
REQ-013 resp_err_o  output  1  access fault flag for this response.
REQ-014 load_en_i  input  1  preload write strobe.
REQ-015 load_addr_i  input  32  preload byte address.
REQ-016 load_data_i  input  32  preload word.

Function
REQ-017 FSM states SHALL be IDLE, WAIT, RESP; req_ready_o = 1 only in IDLE; resp_valid_o = 1 only in RESP.
REQ-018 Request accept SHALL occur on a cycle with req_valid_i & req_ready_o; req_addr_i captured that cycle; later changes to req_addr_i ignored.
REQ-019 On accept: LATENCY = 1 -> next state RESP; else counter <= LATENCY-1, next state WAIT.
REQ-020 In WAIT the counter SHALL decrement each cycle; when counter = 1 next state RESP; resp_valid_o therefore rises exactly LATENCY cycles after the accept edge.
REQ-021 Address fault SHALL be: captured addr[1:0] != 0, or addr < BASE_ADDR, or (addr - BASE_ADDR) >= 4*DEPTH; word index = (addr - BASE_ADDR) >> 2 (32-bit unsigned arithmetic, no wrap hit).
REQ-022 On entering RESP: faulting access -> resp_data_o = 0, resp_err_o = 1; else resp_data_o = mem[index], resp_err_o = 0.
REQ-023 In RESP, resp_data_o and resp_err_o SHALL stay stable until resp_valid_o & resp_ready_i; on that handshake next state IDLE, resp_data_o <= 0, resp_err_o <= 0.
REQ-024 At most one transaction outstanding; no request accepted in WAIT or RESP; minimum spacing between accepts = LATENCY+1 cycles (resp_ready_i held high).
REQ-025 load_en_i SHALL write load_data_i to mem[(load_addr_i - BASE_ADDR)>>2] when aligned and in range, in any FSM state; otherwise write silently dropped.
REQ-026 Load and response capture to the same word in the same cycle SHALL return old data (read-before-write); loads during WAIT before that cycle are visible.
REQ-027 Loads SHALL not alter resp_data_o while in RESP.

Reset
REQ-028 With rst_i high at a clock edge: state <= IDLE, counter <= 0, resp_data_o <= 0, resp_err_o <= 0; after that edge req_ready_o = 1, resp_valid_o = 0.
REQ-029 Reset in WAIT or RESP SHALL abandon the transaction; no response for it is ever produced.
REQ-030 Memory contents SHALL not be affected by reset; load_en_i is honoured during reset.

Verification
REQ-031 Preload mem[0]=32'h00000297 at 0x80000000; request 0x80000000, resp_ready_i=1, LATENCY=2 -> resp_valid_o high exactly 2 cycles after accept, data 32'h00000297, err 0, then IDLE.
REQ-032 Request 0x80000002 -> err 1, data 0; request 0x7FFFFFFC and 0x80001000 (DEPTH=1024) -> err 1, data 0.
REQ-033 Response with resp_ready_i low 5 cycles -> resp_valid_o and data held 5 cycles, req_ready_o low, req_valid_i ignored; accepted on 6th.
REQ-034 Load 32'hDEADBEEF to 0x80000010 during WAIT of a fetch to that address -> response 32'hDEADBEEF; load in the RESP-entry cycle -> old value returned.
REQ-035 rst_i asserted in WAIT -> next cycle req_ready_o 1, resp_valid_o never asserts for that request; memory preserved.
REQ-036 LATENCY=1 build, back-to-back requests with resp_ready_i=1 -> accepts every 2 cycles, each response 1 cycle after accept.
